// File: rtl/triangle_fetch.sv
// Triangle list sequencer: streams triangles 0..n-1 from the list RAM into a
// 4-entry output FIFO and hands them to the consumer over valid/ready.
`timescale 1ns/1ps
module triangle_fetch #(
  parameter int unsigned WI    = 8,
  parameter int unsigned WF    = 8,
  parameter int unsigned Waddr = 7,
  parameter int unsigned SIZE  = 100
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_start,
  input  logic [Waddr:0]           num_tri,
  output logic                     r_en,
  output logic [Waddr-1:0]         r_addr,
  output logic                     ram_is_empty,
  input  logic [(WI+WF)*9-1:0]     ram_data,
  output logic                     tri_valid,
  input  logic                     tri_ready,
  output logic [(WI+WF)*9-1:0]     tri_data,
  output logic                     tri_last,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned W  = (WI + WF) * 9;
  localparam int unsigned CW = Waddr + 1;
  localparam logic [CW-1:0] SizeC = CW'(SIZE);

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e          r_state, w_state_nxt;
  logic [CW-1:0]   r_n, r_rd_ptr, r_sent;
  logic            r_in1;
  logic [W-1:0]    r_fifo [4];
  logic [1:0]      r_wr_idx, r_rd_idx;
  logic [2:0]      r_count;

  logic            w_start, w_push, w_pop, w_final;
  logic [CW-1:0]   w_n_clamp, w_n_last;
  logic [2:0]      w_credit;

  assign w_start   = (r_state == StIdle) & frame_start;
  assign w_n_clamp = (num_tri > SizeC) ? SizeC : num_tri;
  assign w_n_last  = r_n - CW'(1);
  // Credit counts buffered entries plus the one read that may be in flight.
  assign w_credit  = r_count + {2'b00, r_in1};
  assign w_push    = r_in1;
  assign w_pop     = tri_valid & tri_ready;
  assign w_final   = w_pop & (r_sent == w_n_last);

  assign tri_valid    = (r_count != 3'd0);
  assign tri_data     = r_fifo[r_rd_idx];
  assign tri_last     = tri_valid & (r_sent == w_n_last);
  assign r_addr       = r_rd_ptr[Waddr-1:0];
  assign ram_is_empty = (r_n == '0);
  assign busy         = (r_state != StIdle);
  assign frame_done   = (r_state == StDone);

  always_comb begin
    w_state_nxt = r_state;
    r_en        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (frame_start) w_state_nxt = (w_n_clamp != '0) ? StFetch : StDone;
      end
      StFetch: begin
        r_en = (r_rd_ptr < r_n) & (w_credit < 3'd4);
        if (w_final) w_state_nxt = StDone;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= StIdle;
      r_n      <= '0;
      r_rd_ptr <= '0;
      r_sent   <= '0;
      r_in1    <= 1'b0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_in1   <= r_en;
      if (w_start) begin
        r_n      <= w_n_clamp;
        r_rd_ptr <= '0;
        r_sent   <= '0;
      end else begin
        if (r_en)  r_rd_ptr <= r_rd_ptr + CW'(1);
        if (w_pop) r_sent   <= r_sent + CW'(1);
      end
      if (w_push) r_wr_idx <= r_wr_idx + 2'd1;
      if (w_pop)  r_rd_idx <= r_rd_idx + 2'd1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge Clk) begin
    if (w_push) r_fifo[r_wr_idx] <= ram_data;
  end

endmodule
